// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial signed comparator.
// The result-word helper keeps the opcode decode in one place.
package serial_cmp_pkg;

  localparam int WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    GT = 2'd0,
    LT = 2'd1,
    EQ = 2'd2,
    GE = 2'd3
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

  localparam logic [WIDTH_DEFAULT-1:0] TRUE_WORD  = 6'b000001;
  localparam logic [WIDTH_DEFAULT-1:0] FALSE_WORD = 6'b000000;

  function automatic logic [WIDTH_DEFAULT-1:0] cmp_word(cmp_op_e op, logic gt, logic lt);
    logic hit;
    case (op)
      GT:      hit = gt;
      LT:      hit = lt;
      EQ:      hit = ~gt & ~lt;
      default: hit = ~lt;
    endcase
    return hit ? TRUE_WORD : FALSE_WORD;
  endfunction

endpackage

// File: rtl/serial_cmp_bit.sv
// One MSB-first decision step. The sign bit carries negative weight,
// so a set sign bit makes that operand the smaller one.
module serial_cmp_bit (
  input  logic a,
  input  logic b,
  input  logic is_sign,
  input  logic decided,
  input  logic gt,
  input  logic lt,
  output logic decided_next,
  output logic gt_next,
  output logic lt_next
);

  always_comb begin
    decided_next = decided;
    gt_next      = gt;
    lt_next      = lt;
    if (!decided && (a != b)) begin
      decided_next = 1'b1;
      if (is_sign) begin
        gt_next = b;
        lt_next = a;
      end else begin
        gt_next = a;
        lt_next = b;
      end
    end
  end

endmodule

// File: rtl/serial_signed_compare.sv
// Bit-serial two's-complement comparator with valid/ready on both sides.
// Fixed latency of WIDTH SHIFT cycles; no early exit on the first differing bit.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// SHIFT | resolving one bit per edge, MSB first
// DONE  | out_valid high, C held until out_ready
module serial_signed_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  cmp_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  cmp_op_e          op_cap;
  logic             decided;
  logic             gt;
  logic             lt;
  logic             decided_next;
  logic             gt_next;
  logic             lt_next;

  serial_cmp_bit u_bit (
    .a            (a_cap[idx]),
    .b            (b_cap[idx]),
    .is_sign      (idx == LAST_IDX),
    .decided      (decided),
    .gt           (gt),
    .lt           (lt),
    .decided_next (decided_next),
    .gt_next      (gt_next),
    .lt_next      (lt_next)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      a_cap   <= '0;
      b_cap   <= '0;
      op_cap  <= GT;
      decided <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      C       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_cap   <= A;
            b_cap   <= B;
            op_cap  <= cmp_op_e'(op);
            decided <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            idx     <= LAST_IDX;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          decided <= decided_next;
          gt      <= gt_next;
          lt      <= lt_next;
          idx     <= idx - IDX_W'(1);
          // Result is built from the post-LSB flags so C lands with DONE.
          if (idx == '0) begin
            C     <= WIDTH'(cmp_word(op_cap, gt_next, lt_next));
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            C     <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_signed_compare.sv
// Self-checking bench: table vectors, reset/backpressure sequences and an
// all-pairs sweep, with expected words queued at accept and popped at out_valid.
module tb_serial_signed_compare;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] A;
  logic [5:0] B;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] C;

  int checks;
  int failures;

  logic [5:0] exp_q[$];

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] op;
    logic [5:0] exp;
    int         hold;
  } vec_t;

  vec_t vecs[$];

  serial_signed_compare dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model(logic [5:0] a, logic [5:0] b, logic [1:0] o);
    logic r;
    case (o)
      2'd0:    r = $signed(a) >  $signed(b);
      2'd1:    r = $signed(a) <  $signed(b);
      2'd2:    r = $signed(a) == $signed(b);
      default: r = $signed(a) >= $signed(b);
    endcase
    return {5'b00000, r};
  endfunction

  function automatic vec_t mk(logic [5:0] a, logic [5:0] b, logic [1:0] o, logic [5:0] e, int h);
    vec_t v;
    v.a = a; v.b = b; v.op = o; v.exp = e; v.hold = h;
    return v;
  endfunction

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic do_op(input logic [5:0] va, input logic [5:0] vb, input logic [1:0] vop,
                       input logic [5:0] vexp, input int hold);
    int n;
    logic [5:0] held;
    logic [5:0] want;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    A = va; B = vb; op = vop; in_valid = 1'b1;
    exp_q.push_back(vexp);
    @(posedge clk); #1;
    n = 0;
    do begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      A  = 6'($urandom);
      B  = 6'($urandom);
      op = 2'($urandom);
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 12);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("latency", 32'(n), 32'd6);
    chk("done_ready_low", 32'(in_ready), 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: result with empty queue, got C=%0h", C);
    end else begin
      want = exp_q.pop_front();
      chk("result_C", 32'(C), 32'(want));
    end
    held = C;
    repeat (hold) begin
      A = 6'($urandom); B = 6'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_C", 32'(C), 32'(held));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
    chk("release_C", 32'(C), 32'd0);
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; op = '0;

    vecs.push_back(mk(6'b000001, 6'b111111, 2'd0, 6'b000001, 0));
    vecs.push_back(mk(6'b000001, 6'b111111, 2'd1, 6'b000000, 0));
    vecs.push_back(mk(6'b111110, 6'b100000, 2'd0, 6'b000001, 1));
    vecs.push_back(mk(6'b100000, 6'b111110, 2'd0, 6'b000000, 0));
    vecs.push_back(mk(6'b100000, 6'b111110, 2'd1, 6'b000001, 0));
    vecs.push_back(mk(6'b101010, 6'b101010, 2'd2, 6'b000001, 0));
    vecs.push_back(mk(6'b101010, 6'b101010, 2'd3, 6'b000001, 0));
    vecs.push_back(mk(6'b101010, 6'b101010, 2'd0, 6'b000000, 10));
    vecs.push_back(mk(6'b101010, 6'b101010, 2'd1, 6'b000000, 0));
    vecs.push_back(mk(6'b011111, 6'b100000, 2'd0, 6'b000001, 0));
    vecs.push_back(mk(6'b100000, 6'b011111, 2'd1, 6'b000001, 2));
    vecs.push_back(mk(6'b011111, 6'b011110, 2'd2, 6'b000000, 0));
    vecs.push_back(mk(6'b000011, 6'b000101, 2'd3, 6'b000000, 0));
    vecs.push_back(mk(6'b000000, 6'b000000, 2'd3, 6'b000001, 0));
    vecs.push_back(mk(6'b111111, 6'b000000, 2'd3, 6'b000000, 3));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_C", 32'(C), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].hold);

    // Reset mid-SHIFT discards the operation.
    A = 6'sd5; B = 6'sd3; op = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("shift_busy", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midshift_in_ready", 32'(in_ready), 32'd1);
    chk("midshift_out_valid", 32'(out_valid), 32'd0);
    chk("midshift_C", 32'(C), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(6'sd5, 6'sd3, 2'd0, 6'b000001, 0);
    do_op(6'sd5, 6'sd3, 2'd2, 6'b000000, 0);

    // Reset while a true result is held in DONE.
    A = 6'b011111; B = 6'b000000; op = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    chk("done_latency", 32'(n), 32'd6);
    chk("done_C", 32'(C), 32'd1);
    reset = 1'b1;
    #1;
    chk("done_reset_C", 32'(C), 32'd0);
    chk("done_reset_out_valid", 32'(out_valid), 32'd0);
    chk("done_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 4096; i++) begin
      logic [5:0] ea;
      logic [5:0] eb;
      logic [1:0] eo;
      ea = 6'(i >> 6);
      eb = 6'(i);
      eo = 2'(i ^ (i >> 6) ^ (i >> 2));
      do_op(ea, eb, eo, model(ea, eb, eo), $urandom_range(0, 2));
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
